// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file.
// Holds the clear-sequencer state encoding and address-width helper.
package regfile_pkg;

  localparam int REGFILE_XLEN  = 32;
  localparam int REGFILE_NREGS = 32;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: walks every register index once to flush the file.
// Busy/we come straight from the state flop, so no input reaches them.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = REGFILE_NREGS,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_t    state, state_n;
  logic [AW-1:0] idx, idx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      CLR_IDLE: begin
        if (clr_start) begin
          state_n = CLR_SWEEP;
          idx_n   = '0;
        end
      end
      CLR_SWEEP: begin
        idx_n = idx + 1'b1;
        if (idx == LAST) begin
          state_n = CLR_IDLE;
          idx_n   = '0;
        end
      end
      default: state_n = CLR_IDLE;
    endcase
  end

  assign clr_busy = (state == CLR_SWEEP);
  assign clr_we   = clr_busy;
  assign clr_idx  = idx;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: one write port, NRD registered read ports, optional zero
// register, write-to-read bypass and a sweeping clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  XLEN     = REGFILE_XLEN,
  parameter int  NREGS    = REGFILE_NREGS,
  parameter int  NRD      = 2,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  input  logic                clr_start,
  output logic                clr_busy
);

  logic [XLEN-1:0] mem [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  logic            wr_ok;

  regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr (
    .clk       (clk),
    .reset     (reset),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  // Writes are frozen for the whole sweep; a dropped write never bypasses.
  always_comb begin
    wr_ok = wr_en && !clr_busy && (32'(wr_addr) < NREGS);
    if (ZERO_REG && (wr_addr == '0))
      wr_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] data_q;
    logic            valid_q;
    logic            ok;

    assign ra = rd_addr[g*AW +: AW];

    always_comb begin
      ok = (32'(ra) < NREGS);
      if (ZERO_REG && (ra == '0))
        ok = 1'b0;
      q = '0;
      if (ok) begin
        if (BYPASS && wr_ok && (wr_addr == ra))
          q = wr_data;
        else
          q = mem[ra];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_en[g];
        if (rd_en[g])
          data_q <= q;
      end
    end

    assign rd_data[g*XLEN +: XLEN] = data_q;
    assign rd_valid[g]             = valid_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a default instance and a 20-reg/3-port/64-bit
// no-bypass instance with shared stimulus, checked against an array model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [2:0]  rd_en;
  logic [4:0]  ra [3];
  logic        clr_start;

  logic [63:0]  rd_data_a;
  logic [1:0]   rd_valid_a;
  logic         busy_a;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_valid_b;
  logic         busy_b;

  always #5 clk = ~clk;

  regfile_mp u_a (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data[31:0]),
    .rd_en     (rd_en[1:0]),
    .rd_addr   ({ra[1], ra[0]}),
    .rd_data   (rd_data_a),
    .rd_valid  (rd_valid_a),
    .clr_start (clr_start),
    .clr_busy  (busy_a)
  );

  regfile_mp #(
    .XLEN   (64),
    .NREGS  (20),
    .NRD    (3),
    .BYPASS (1'b0)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   ({ra[2], ra[1], ra[0]}),
    .rd_data   (rd_data_b),
    .rd_valid  (rd_valid_b),
    .clr_start (clr_start),
    .clr_busy  (busy_b)
  );

  int          NR [2] = '{32, 20};
  int          NP [2] = '{2, 3};
  bit          BP [2] = '{1'b1, 1'b0};
  logic [63:0] MK [2] = '{64'h0000_0000_FFFF_FFFF, '1};

  logic [63:0] mem [2][32];
  logic [63:0] ed  [2][3];
  logic [2:0]  ev  [2];
  int          left [2];

  int checks = 0;
  int passes = 0;

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit wok;
      if (reset) begin
        for (int r = 0; r < 32; r++) mem[d][r] = '0;
        for (int p = 0; p < 3; p++) ed[d][p] = '0;
        ev[d]   = '0;
        left[d] = 0;
        continue;
      end
      wok = wr_en && left[d] == 0 && int'(wr_addr) < NR[d] && wr_addr != 0;
      for (int p = 0; p < NP[d]; p++) begin
        if (rd_en[p]) begin
          if (int'(ra[p]) >= NR[d] || ra[p] == 0)
            ed[d][p] = '0;
          else if (BP[d] && wok && wr_addr == ra[p])
            ed[d][p] = wr_data & MK[d];
          else
            ed[d][p] = mem[d][ra[p]];
          ev[d][p] = 1'b1;
        end else begin
          ev[d][p] = 1'b0;
        end
      end
      if (left[d] > 0) begin
        mem[d][NR[d] - left[d]] = '0;
        left[d]--;
      end else if (clr_start) begin
        left[d] = NR[d];
      end
      if (wok) mem[d][wr_addr] = wr_data & MK[d];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s got %h exp %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("busy_a", 64'(busy_a), 64'(left[0] > 0));
    chk("busy_b", 64'(busy_b), 64'(left[1] > 0));
    chk("valid_a", 64'(rd_valid_a), 64'(ev[0][1:0]));
    chk("valid_b", 64'(rd_valid_b), 64'(ev[1]));
    for (int p = 0; p < 2; p++)
      chk($sformatf("data_a%0d", p), 64'(rd_data_a[p*32 +: 32]), ed[0][p]);
    for (int p = 0; p < 3; p++)
      chk($sformatf("data_b%0d", p), rd_data_b[p*64 +: 64], ed[1][p]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_en     = '0;
    clr_start = 1'b0;
    for (int p = 0; p < 3; p++) ra[p] = '0;
  endtask

  task automatic rd_all(input logic [4:0] a);
    rd_en = 3'b111;
    for (int p = 0; p < 3; p++) ra[p] = a;
  endtask

  task automatic write(input logic [4:0] a, input logic [63:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
  endtask

  task automatic fill();
    idle();
    for (int r = 0; r < 32; r++) begin
      write(5'(r), {$urandom, $urandom} | 64'h1);
      step();
    end
    idle();
  endtask

  task automatic sweep_reads_zero();
    idle();
    for (int r = 0; r < 32; r++) begin
      rd_all(5'(r));
      step();
      chk("clr_zero_a", 64'(rd_data_a[31:0]), 64'h0);
      chk("clr_zero_b", rd_data_b[63:0], 64'h0);
    end
    idle();
  endtask

  initial begin
    int ncyc_a;
    int ncyc_b;

    idle();
    reset = 1'b1;
    step();
    step();
    idle();

    for (int r = 0; r < 32; r++) begin
      rd_all(5'(r));
      step();
      chk("rst_valid", 64'(rd_valid_a), 64'h3);
    end

    idle();
    write(5'd5, 64'hDEAD_BEEF);
    step();
    idle();
    rd_all(5'd5);
    step();
    chk("r5_a0", 64'(rd_data_a[31:0]), 64'hDEAD_BEEF);
    chk("r5_a1", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);
    chk("r5_valid", 64'(rd_valid_a), 64'h3);

    idle();
    write(5'd7, 64'h1);
    step();
    write(5'd7, 64'h55);
    rd_all(5'd7);
    step();
    chk("byp_a", 64'(rd_data_a[31:0]), 64'h55);
    chk("nobyp_b", rd_data_b[63:0], 64'h1);
    write(5'd0, 64'h99);
    rd_all(5'd0);
    step();
    chk("r0_byp_a", 64'(rd_data_a[31:0]), 64'h0);

    idle();
    write(5'd3, 64'h33);
    step();
    idle();
    rd_all(5'd3);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      write(5'd3, 64'h1000 + 64'(i));
      step();
      chk("hold_a", 64'(rd_data_a[31:0]), 64'h33);
      chk("hold_valid", 64'(rd_valid_a), 64'h0);
    end

    fill();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    ncyc_a = 0;
    ncyc_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) ncyc_a++;
      if (busy_b) ncyc_b++;
      idle();
      rd_en = 3'($urandom);
      for (int p = 0; p < 3; p++) ra[p] = 5'($urandom);
      if (i == 5) write(5'd9, 64'hABCD);
      if (i == 10) clr_start = 1'b1;
      step();
    end
    chk("busy_len_a", 64'(ncyc_a), 64'd32);
    chk("busy_len_b", 64'(ncyc_b), 64'd20);
    sweep_reads_zero();

    fill();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    chk("rst_mid_busy", 64'(busy_a), 64'h0);
    sweep_reads_zero();

    write(5'd20, 64'h1234_5678_9ABC_DEF0);
    step();
    idle();
    rd_all(5'd20);
    step();
    chk("oor_b", rd_data_b[63:0], 64'h0);
    chk("in_a", 64'(rd_data_a[31:0]), 64'h9ABC_DEF0);

    for (int i = 0; i < 500; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clr_start = ($urandom_range(0, 49) == 0);
      wr_en     = 1'($urandom);
      wr_addr   = 5'($urandom);
      wr_data   = {$urandom, $urandom};
      rd_en     = 3'($urandom);
      for (int p = 0; p < 3; p++)
        ra[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
